// File: rtl/adder_err_pkg.sv
// Shared types and default sizing for the adder error monitor.
package adder_err_pkg;

   localparam int unsigned DefWidth = 16;
   localparam int unsigned DefCntW  = 32;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDrain,
      StDone
   } state_e;

endpackage

// File: rtl/adder_err_monitor_if.sv
// Sample bus: operands and approximate result from the adder under test.
interface adder_err_monitor_if
   import adder_err_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;
   logic [WIDTH:0]   approx_sum;

   modport master (
      output in_valid,
      output op_a,
      output op_b,
      output op_cin,
      output approx_sum,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  op_a,
      input  op_b,
      input  op_cin,
      input  approx_sum,
      output in_ready
   );

endinterface

// File: rtl/adder_err_monitor_err_calc_stage.sv
// Stage 1: exact reference sum and error terms, registered on the accept edge.
module err_calc_stage
   import adder_err_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_accept,
   input  logic [WIDTH-1:0] i_op_a,
   input  logic [WIDTH-1:0] i_op_b,
   input  logic             i_op_cin,
   input  logic [WIDTH:0]   i_approx_sum,
   output logic             o_valid,
   output logic [WIDTH+1:0] o_diff,
   output logic [WIDTH:0]   o_abs,
   output logic             o_mismatch
);

   logic [WIDTH:0]   w_exact;
   logic [WIDTH+1:0] w_diff;
   logic [WIDTH:0]   w_abs;
   logic             w_mismatch;

   logic             r_valid;
   logic [WIDTH+1:0] r_diff;
   logic [WIDTH:0]   r_abs;
   logic             r_mismatch;

   // Combinational error terms; the extra diff bit carries the sign.
   always_comb begin
      w_exact    = {1'b0, i_op_a} + {1'b0, i_op_b} + {{WIDTH{1'b0}}, i_op_cin};
      w_diff     = {1'b0, w_exact} - {1'b0, i_approx_sum};
      w_abs      = (w_exact >= i_approx_sum) ? (w_exact - i_approx_sum)
                                             : (i_approx_sum - w_exact);
      w_mismatch = (w_exact != i_approx_sum);
   end

   // Capture error terms only for accepted samples; valid marks them for stage 2.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_diff     <= '0;
         r_abs      <= '0;
         r_mismatch <= 1'b0;
      end else begin
         r_valid <= i_accept;
         if (i_accept) begin
            r_diff     <= w_diff;
            r_abs      <= w_abs;
            r_mismatch <= w_mismatch;
         end
      end
   end

   assign o_valid    = r_valid;
   assign o_diff     = r_diff;
   assign o_abs      = r_abs;
   assign o_mismatch = r_mismatch;

endmodule

// File: rtl/adder_err_monitor.sv
// Measures error statistics of an approximate adder over a run of n samples.
module adder_err_monitor
   import adder_err_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_start,
   input  logic [CNT_W-1:0]       i_n_samples,
   adder_err_monitor_if.slave     bus,
   output logic                   o_busy,
   output logic                   o_done,
   output logic [CNT_W-1:0]       o_sample_cnt,
   output logic [CNT_W-1:0]       o_err_cnt,
   output logic [WIDTH+CNT_W:0]   o_sum_ed,
   output logic [WIDTH+CNT_W+1:0] o_sum_oe,
   output logic [WIDTH:0]         o_max_ed
);

   localparam int unsigned EdW = WIDTH + CNT_W + 1;
   localparam int unsigned OeW = WIDTH + CNT_W + 2;

   state_e           r_state;
   state_e           w_state_d;
   logic             r_busy;
   logic             r_done;
   logic             w_busy_d;
   logic             w_done_d;
   logic             w_in_ready;

   logic [CNT_W-1:0] r_n_cap;
   logic [CNT_W-1:0] r_acc_cnt;
   logic             w_accept;
   logic             w_last;
   logic             w_start_acc;

   logic             w_s1_valid;
   logic [WIDTH+1:0] w_s1_diff;
   logic [WIDTH:0]   w_s1_abs;
   logic             w_s1_mismatch;

   logic [CNT_W-1:0] r_sample_cnt;
   logic [CNT_W-1:0] r_err_cnt;
   logic [EdW-1:0]   r_sum_ed;
   logic [OeW-1:0]   r_sum_oe;
   logic [WIDTH:0]   r_max_ed;

   assign w_start_acc = (r_state == StIdle) && i_start;
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_last      = ((r_acc_cnt + CNT_W'(1)) == r_n_cap);

   err_calc_stage #(
      .WIDTH (WIDTH)
   ) u_stage1 (
      .clk          (clk),
      .rst          (rst),
      .i_accept     (w_accept),
      .i_op_a       (bus.op_a),
      .i_op_b       (bus.op_b),
      .i_op_cin     (bus.op_cin),
      .i_approx_sum (bus.approx_sum),
      .o_valid      (w_s1_valid),
      .o_diff       (w_s1_diff),
      .o_abs        (w_s1_abs),
      .o_mismatch   (w_s1_mismatch)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_d;
      end
   end

   // FSM next state; a zero-length run skips straight to DRAIN.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_d = (i_n_samples == '0) ? StDrain : StRun;
            end
         end
         StRun: begin
            if (w_accept && w_last) begin
               w_state_d = StDrain;
            end
         end
         StDrain: w_state_d = StDone;
         StDone:  w_state_d = StIdle;
      endcase
   end

   // FSM outputs: busy/done decoded from next state so they can be registered.
   always_comb begin
      w_busy_d   = (w_state_d != StIdle);
      w_done_d   = (w_state_d == StDone);
      w_in_ready = (r_state == StRun) && (r_acc_cnt < r_n_cap);
   end

   // Registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_busy <= w_busy_d;
         r_done <= w_done_d;
      end
   end

   // Run length capture and accepted-sample count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_n_cap   <= '0;
         r_acc_cnt <= '0;
      end else if (w_start_acc) begin
         r_n_cap   <= i_n_samples;
         r_acc_cnt <= '0;
      end else if (w_accept) begin
         r_acc_cnt <= r_acc_cnt + CNT_W'(1);
      end
   end

   // Stage 2: accumulate statistics one edge after each accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_sum_ed     <= '0;
         r_sum_oe     <= '0;
         r_max_ed     <= '0;
      end else if (w_start_acc) begin
         r_sample_cnt <= '0;
         r_err_cnt    <= '0;
         r_sum_ed     <= '0;
         r_sum_oe     <= '0;
         r_max_ed     <= '0;
      end else if (w_s1_valid) begin
         r_sample_cnt <= r_sample_cnt + CNT_W'(1);
         r_err_cnt    <= r_err_cnt + CNT_W'(w_s1_mismatch);
         r_sum_ed     <= r_sum_ed + {{CNT_W{1'b0}}, w_s1_abs};
         r_sum_oe     <= r_sum_oe + {{CNT_W{w_s1_diff[WIDTH+1]}}, w_s1_diff};
         if (w_s1_abs > r_max_ed) begin
            r_max_ed <= w_s1_abs;
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_sample_cnt  = r_sample_cnt;
   assign o_err_cnt     = r_err_cnt;
   assign o_sum_ed      = r_sum_ed;
   assign o_sum_oe      = r_sum_oe;
   assign o_max_ed      = r_max_ed;

endmodule

// File: tb/tb_adder_err_monitor.sv
// Directed self-checking bench for adder_err_monitor.
module tb_adder_err_monitor;

   localparam int unsigned Width = 16;
   localparam int unsigned CntW  = 32;
   localparam int unsigned EdW   = Width + CntW + 1;
   localparam int unsigned OeW   = Width + CntW + 2;

   logic             clk;
   logic             rst;
   logic             r_start;
   logic [CntW-1:0]  r_n_samples;
   logic             w_busy;
   logic             w_done;
   logic [CntW-1:0]  w_sample_cnt;
   logic [CntW-1:0]  w_err_cnt;
   logic [EdW-1:0]   w_sum_ed;
   logic [OeW-1:0]   w_sum_oe;
   logic [Width:0]   w_max_ed;

   int n_total = 0;
   int n_bad   = 0;

   adder_err_monitor_if #(.WIDTH(Width)) bus ();

   adder_err_monitor #(
      .WIDTH (Width),
      .CNT_W (CntW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .i_start      (r_start),
      .i_n_samples  (r_n_samples),
      .bus          (bus),
      .o_busy       (w_busy),
      .o_done       (w_done),
      .o_sample_cnt (w_sample_cnt),
      .o_err_cnt    (w_err_cnt),
      .o_sum_ed     (w_sum_ed),
      .o_sum_oe     (w_sum_oe),
      .o_max_ed     (w_max_ed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Two's-complement encoding of a signed value at sum_oe width.
   function automatic logic [OeW-1:0] oe(input longint v);
      return OeW'(v);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [CntW-1:0] n);
      r_start     = 1'b1;
      r_n_samples = n;
      tick();
      r_start     = 1'b0;
   endtask

   task automatic send(input logic [Width-1:0] a, input logic [Width-1:0] b,
                       input logic c, input logic [Width:0] s);
      bus.in_valid   = 1'b1;
      bus.op_a       = a;
      bus.op_b       = b;
      bus.op_cin     = c;
      bus.approx_sum = s;
      for (int k = 0; k < 20 && !bus.in_ready; k++) tick();
      chk("send_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic chk_stats(input string tag, input logic [CntW-1:0] sc, input logic [CntW-1:0] ec,
                            input logic [EdW-1:0] ed, input logic [OeW-1:0] so,
                            input logic [Width:0] mx);
      chk({tag, "_sample_cnt"}, 64'(w_sample_cnt), 64'(sc));
      chk({tag, "_err_cnt"},    64'(w_err_cnt),    64'(ec));
      chk({tag, "_sum_ed"},     64'(w_sum_ed),     64'(ed));
      chk({tag, "_sum_oe"},     64'(w_sum_oe),     64'(so));
      chk({tag, "_max_ed"},     64'(w_max_ed),     64'(mx));
   endtask

   logic             pat [6];
   logic [Width-1:0] sa [3];
   logic [Width-1:0] sb [3];
   logic             sc [3];
   logic [Width:0]   ss [3];
   int               acc;
   int               di;
   logic             seen_done;

   initial begin
      rst            = 1'b1;
      r_start        = 1'b0;
      r_n_samples    = '0;
      bus.in_valid   = 1'b0;
      bus.op_a       = '0;
      bus.op_b       = '0;
      bus.op_cin     = 1'b0;
      bus.approx_sum = '0;

      // Reset state
      tick();
      tick();
      chk("rst_busy", 64'(w_busy), 64'd0);
      chk("rst_done", 64'(w_done), 64'd0);
      chk("rst_ready", 64'(bus.in_ready), 64'd0);
      chk_stats("rst", 0, 0, 0, oe(0), 0);
      rst = 1'b0;
      tick();

      // Exact adder, 4 samples
      do_start(4);
      chk("t1_busy", 64'(w_busy), 64'd1);
      chk("t1_ready", 64'(bus.in_ready), 64'd1);
      send(16'h0001, 16'h0002, 1'b0, 17'h00003);
      send(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF);
      send(16'h1234, 16'h4321, 1'b1, 17'h05556);
      send(16'h0000, 16'h0000, 1'b0, 17'h00000);
      chk("t1_drain_ready", 64'(bus.in_ready), 64'd0);
      chk("t1_drain_done", 64'(w_done), 64'd0);
      tick();
      chk("t1_done", 64'(w_done), 64'd1);
      chk_stats("t1", 4, 0, 0, oe(0), 0);
      tick();
      chk("t1_idle_done", 64'(w_done), 64'd0);
      chk("t1_idle_busy", 64'(w_busy), 64'd0);

      // Single sample with error +256
      do_start(1);
      send(16'h00FF, 16'h0001, 1'b0, 17'h00000);
      tick();
      chk("t2_done", 64'(w_done), 64'd1);
      chk_stats("t2", 1, 1, 256, oe(256), 256);
      tick();

      // Errors -2 then +1
      do_start(2);
      send(16'd2, 16'd3, 1'b0, 17'd7);
      send(16'd4, 16'd5, 1'b1, 17'd9);
      tick();
      chk("t3_done", 64'(w_done), 64'd1);
      chk_stats("t3", 2, 2, 3, oe(-1), 2);
      tick();

      // Zero-length run
      do_start(0);
      chk("t4_busy0", 64'(w_busy), 64'd1);
      chk("t4_done0", 64'(w_done), 64'd0);
      chk("t4_ready0", 64'(bus.in_ready), 64'd0);
      tick();
      chk("t4_busy1", 64'(w_busy), 64'd1);
      chk("t4_done1", 64'(w_done), 64'd1);
      chk("t4_ready1", 64'(bus.in_ready), 64'd0);
      chk_stats("t4", 0, 0, 0, oe(0), 0);
      tick();
      chk("t4_busy2", 64'(w_busy), 64'd0);
      chk("t4_done2", 64'(w_done), 64'd0);

      // Gapped valid, start during RUN ignored
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      sa[0] = 16'd10;  sb[0] = 16'd20; sc[0] = 1'b0; ss[0] = 17'd30;
      sa[1] = 16'd100; sb[1] = 16'd1;  sc[1] = 1'b1; ss[1] = 17'd100;
      sa[2] = 16'd7;   sb[2] = 16'd7;  sc[2] = 1'b0; ss[2] = 17'd20;
      acc = 0;
      di  = 0;
      do_start(3);
      for (int c = 0; c < 6; c++) begin
         bus.in_valid   = pat[c];
         bus.op_a       = sa[di];
         bus.op_b       = sb[di];
         bus.op_cin     = sc[di];
         bus.approx_sum = ss[di];
         if (c == 2) begin
            r_start     = 1'b1;
            r_n_samples = 7;
         end
         if (bus.in_valid && bus.in_ready) acc++;
         tick();
         r_start = 1'b0;
         if (acc > di && di < 2) di++;
      end
      bus.in_valid = 1'b0;
      chk("t5_accepts", 64'(acc), 64'd3);
      chk("t5_drain_ready", 64'(bus.in_ready), 64'd0);
      chk("t5_drain_done", 64'(w_done), 64'd0);
      tick();
      chk("t5_done", 64'(w_done), 64'd1);
      chk_stats("t5", 3, 2, 8, oe(-4), 6);
      tick();
      chk("t5_idle_busy", 64'(w_busy), 64'd0);

      // Reset mid-run
      do_start(5);
      send(16'h00FF, 16'h0001, 1'b0, 17'h00000);
      send(16'd3, 16'd3, 1'b0, 17'd6);
      tick();
      chk_stats("t6_pre", 2, 1, 256, oe(256), 256);
      rst = 1'b1;
      #1;
      chk("t6_rst_busy", 64'(w_busy), 64'd0);
      chk("t6_rst_ready", 64'(bus.in_ready), 64'd0);
      chk_stats("t6_rst", 0, 0, 0, oe(0), 0);
      seen_done = 1'b0;
      tick();
      seen_done |= w_done;
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         seen_done |= w_done;
      end
      chk("t6_no_done", 64'(seen_done), 64'd0);
      chk("t6_idle_busy", 64'(w_busy), 64'd0);
      do_start(1);
      send(16'd1, 16'd1, 1'b0, 17'd2);
      tick();
      chk("t6_done", 64'(w_done), 64'd1);
      chk_stats("t6_new", 1, 0, 0, oe(0), 0);
      tick();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/adder_err_monitor.md
ADDER_ERR_MONITOR -- requirements
Module: adder_err_monitor

Interface
REQ-001 Parameter WIDTH, default 16, operand width of the adder under test.
REQ-002 Parameter CNT_W, default 32, width of sample and error counters.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begins a measurement run; sampled only in IDLE.
REQ-006 n_samples  input  CNT_W  number of samples in the run; captured when start is accepted.
REQ-007 in_valid  input  1  sample present on op_a/op_b/op_cin/approx_sum.
REQ-008 in_ready  output  1  monitor accepts a sample this cycle.
REQ-009 op_a, op_b  input  WIDTH each  adder operands.
REQ-010 op_cin  input  1  adder carry-in.
REQ-011 approx_sum  input  WIDTH+1  adder result as {cout,sum}.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse; statistics final.
REQ-014 sample_cnt, err_cnt  output  CNT_W each  samples accumulated; samples with approx_sum != exact.
REQ-015 sum_ed  output  WIDTH+CNT_W+1  unsigned sum of |exact - approx|.
REQ-016 sum_oe  output  WIDTH+CNT_W+2  signed two's-complement sum of (exact - approx).
REQ-017 max_ed  output  WIDTH+1  largest |exact - approx| seen in the run.

Function
REQ-018 States: IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE + start: capture n_samples, clear all statistics, go to RUN; if n_samples==0, go to DRAIN instead.
REQ-020 start outside IDLE is ignored.
REQ-021 in_ready = 1 only in RUN while accepted count < captured n_samples; a sample is accepted when in_valid & in_ready.
REQ-022 RUN -> DRAIN on the edge that accepts the n_samples-th sample.
REQ-023 DRAIN -> DONE after exactly one cycle; DONE -> IDLE after exactly one cycle; done = 1 only in DONE.
REQ-024 Stage 1 (registered on the accept edge): exact = op_a + op_b + op_cin (WIDTH+1 bits, no overflow), signed diff = exact - approx_sum, abs diff, mismatch flag.
REQ-025 Stage 2 (next edge): sample_cnt += 1; err_cnt += mismatch; sum_ed += abs; sum_oe += diff; max_ed = max(max_ed, abs).
REQ-026 Accept-to-statistics latency: 2 edges; statistics stable from DONE until the next accepted start.
REQ-027 Accumulator widths are sized so no overflow is possible for any n_samples; no saturation logic.
REQ-028 Gaps in in_valid stall accepts only; in-flight stage-1 data still accumulates.
REQ-029 Outputs are registered; no combinational input-to-output path except in_ready from state/count.

Reset
REQ-030 On rst: state IDLE; in_ready, busy, done = 0; all statistics, counters, stage-1 valid = 0.
REQ-031 rst mid-run discards the run immediately; no done pulse is produced for it.

Structure
REQ-032 Package adder_err_pkg holds the state enum and default WIDTH/CNT_W constants.
REQ-033 Stage 1 is the sub-module err_calc_stage (exact sum, signed diff, abs diff, mismatch flag, valid register).

Verification
REQ-034 n_samples=4, approx_sum always equal to exact -> done after 4 accepts; sample_cnt=4, err_cnt=0, sum_ed=0, sum_oe=0, max_ed=0.
REQ-035 One sample a=0x00FF, b=0x0001, cin=0, approx=0x00000 -> err_cnt=1, sum_ed=256, sum_oe=+256, max_ed=256.
REQ-036 Samples (exact 5, approx 7) then (exact 10, approx 9) -> err_cnt=2, sum_ed=3, sum_oe=-1, max_ed=2.
REQ-037 start with n_samples=0 -> busy for 2 cycles (DRAIN, DONE); done pulses 2 cycles after start edge; in_ready never 1; statistics 0.
REQ-038 n_samples=3 with in_valid toggling 1,0,0,1,0,1 -> exactly 3 accepts; done 2 cycles after third accept; start during RUN ignored.
REQ-039 rst asserted after 2 of 5 samples -> all outputs 0 immediately, no done; new start runs cleanly from zero.
